// File: rtl/xbar_pkg.sv
// ============================================================================
// Module      : xbar_pkg
// Description : Shared types and constants for the 2x2 crossbar scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package xbar_pkg;

  localparam int DATA_W_DEF = 4;

  localparam logic DEST_OUT0 = 1'b0;
  localparam logic DEST_OUT1 = 1'b1;

  localparam logic XBAR_STRAIGHT = 1'b0;
  localparam logic XBAR_CROSS    = 1'b1;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic                  dest;
  } flit_t;

endpackage

`default_nettype wire

// File: rtl/xbar_flit_fifo.sv
// ============================================================================
// Module      : xbar_flit_fifo
// Description : Synchronous FIFO with push/pop and full/empty flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xbar_flit_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit tells a full FIFO apart from an empty one.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

`default_nettype wire

// File: rtl/crossbar_2x2_sched.sv
// ============================================================================
// Module      : crossbar_2x2_sched
// Description : Request-side scheduler for a 2x2 crossbar: input FIFOs,
//               round-robin conflict arbitration, registered output ports.
//               Optional conflict counter enabled by XBAR_CONFLICT_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crossbar_2x2_sched
  import xbar_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in0_valid,
  output logic              in0_ready,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_dest,
  input  logic              in1_valid,
  output logic              in1_ready,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_dest,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic              out0_src,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic              out1_src,
`ifdef XBAR_CONFLICT_CNT_EN
  output logic [CNT_W-1:0]  conflict_cnt,
`endif
  output logic              xbar_cross
);

  localparam int FLIT_W = DATA_W + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CNT_W < 1) begin : g_bad_params
    $error("crossbar_2x2_sched: FIFO_DEPTH must be a power of two >= 2, CNT_W >= 1");
  end

  logic [FLIT_W-1:0] w_head [2];
  logic [1:0]        w_empty;
  logic [1:0]        w_full;
  logic [1:0]        w_push;
  logic [1:0]        w_req;
  logic [1:0]        w_dest;
  logic [1:0]        w_free;
  logic [1:0]        w_gnt;
  logic [1:0]        w_slot_gnt;
  logic [1:0]        w_slot_src;
  logic [1:0]        w_in_valid;
  logic [1:0]        w_out_ready;
  logic              w_conflict;

  logic [1:0]        r_out_valid;
  logic [1:0]        r_out_src;
  logic [DATA_W-1:0] r_out_data [2];
  logic              r_prio;
  logic              r_cross;

  assign w_in_valid  = {in1_valid, in0_valid};
  assign w_out_ready = {out1_ready, out0_ready};
  assign w_push      = w_in_valid & ~w_full;

  assign in0_ready  = ~w_full[0];
  assign in1_ready  = ~w_full[1];
  assign out0_valid = r_out_valid[0];
  assign out1_valid = r_out_valid[1];
  assign out0_data  = r_out_data[0];
  assign out1_data  = r_out_data[1];
  assign out0_src   = r_out_src[0];
  assign out1_src   = r_out_src[1];
  assign xbar_cross = r_cross;

  xbar_flit_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(FLIT_W)) u_fifo0 (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push[0]),
    .i_data  ({in0_data, in0_dest}),
    .i_pop   (w_gnt[0]),
    .o_data  (w_head[0]),
    .o_full  (w_full[0]),
    .o_empty (w_empty[0])
  );

  xbar_flit_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(FLIT_W)) u_fifo1 (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push[1]),
    .i_data  ({in1_data, in1_dest}),
    .i_pop   (w_gnt[1]),
    .o_data  (w_head[1]),
    .o_full  (w_full[1]),
    .o_empty (w_empty[1])
  );

  always_comb begin
    w_req      = ~w_empty;
    w_dest     = {w_head[1][0], w_head[0][0]};
    w_free     = ~r_out_valid | w_out_ready;
    w_conflict = (&w_req) && (w_dest[0] == w_dest[1]);
    w_gnt      = '0;
    // On a collision only the favoured input may take the slot; the other waits.
    if (w_conflict) begin
      w_gnt[r_prio] = w_free[w_dest[0]];
    end else begin
      w_gnt[0] = w_req[0] && w_free[w_dest[0]];
      w_gnt[1] = w_req[1] && w_free[w_dest[1]];
    end
    for (int k = 0; k < 2; k++) begin
      w_slot_gnt[k] = (w_gnt[0] && (w_dest[0] == 1'(k))) ||
                      (w_gnt[1] && (w_dest[1] == 1'(k)));
      w_slot_src[k] = w_gnt[1] && (w_dest[1] == 1'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid   <= '0;
      r_out_src     <= '0;
      r_out_data[0] <= '0;
      r_out_data[1] <= '0;
      r_prio        <= 1'b0;
      r_cross       <= XBAR_STRAIGHT;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (w_slot_gnt[k]) begin
          r_out_valid[k] <= 1'b1;
          r_out_src[k]   <= w_slot_src[k];
          r_out_data[k]  <= w_slot_src[k] ? w_head[1][FLIT_W-1:1] : w_head[0][FLIT_W-1:1];
        end else if (w_free[k]) begin
          r_out_valid[k] <= 1'b0;
        end
      end
      if (|w_gnt) begin
        r_cross <= ((w_gnt[0] && (w_dest[0] != DEST_OUT0)) ||
                    (w_gnt[1] && (w_dest[1] != DEST_OUT1))) ? XBAR_CROSS : XBAR_STRAIGHT;
      end
      if (w_conflict && (|w_gnt)) r_prio <= ~r_prio;
    end
  end

`ifdef XBAR_CONFLICT_CNT_EN
  logic [CNT_W-1:0] r_conflict_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_conflict_cnt <= '0;
    end else if (w_conflict && (r_conflict_cnt != '1)) begin
      r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
    end
  end

  assign conflict_cnt = r_conflict_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_crossbar_2x2_sched.sv
// ============================================================================
// Module      : tb_crossbar_2x2_sched
// Description : Scoreboard bench for crossbar_2x2_sched (directed + random).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_crossbar_2x2_sched;
  import xbar_pkg::*;

  localparam int DW = DATA_W_DEF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in0_valid = 1'b0, in1_valid = 1'b0;
  logic          in0_ready, in1_ready;
  logic [DW-1:0] in0_data = '0, in1_data = '0;
  logic          in0_dest = 1'b0, in1_dest = 1'b0;
  logic          out0_valid, out1_valid;
  logic          out0_ready = 1'b1, out1_ready = 1'b1;
  logic [DW-1:0] out0_data, out1_data;
  logic          out0_src, out1_src;
  logic          xbar_cross;
`ifdef XBAR_CONFLICT_CNT_EN
  logic [7:0]    conflict_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Expected flits per (src,dest) pair, index = {src,dest}.
  logic [DW-1:0] exp_q [4][$];
  // Everything delivered on each output, in delivery order.
  logic [DW-1:0] log_d [2][$];
  logic          log_s [2][$];

  crossbar_2x2_sched dut (
    .clk        (clk),
    .rst        (rst),
    .in0_valid  (in0_valid),
    .in0_ready  (in0_ready),
    .in0_data   (in0_data),
    .in0_dest   (in0_dest),
    .in1_valid  (in1_valid),
    .in1_ready  (in1_ready),
    .in1_data   (in1_data),
    .in1_dest   (in1_dest),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out0_src   (out0_src),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .out1_src   (out1_src),
`ifdef XBAR_CONFLICT_CNT_EN
    .conflict_cnt (conflict_cnt),
`endif
    .xbar_cross (xbar_cross)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Record accepted flits before the edge, then advance to just after it.
  task automatic step();
    @(negedge clk);
    if (!rst) begin
      if (in0_valid && in0_ready) exp_q[int'({1'b0, in0_dest})].push_back(in0_data);
      if (in1_valid && in1_ready) exp_q[int'({1'b1, in1_dest})].push_back(in1_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) exp_q[i].delete();
    for (int k = 0; k < 2; k++) begin
      log_d[k].delete();
      log_s[k].delete();
    end
  endtask

  task automatic drive(input logic v0, input flit_t f0, input logic v1, input flit_t f1);
    in0_valid = v0; in0_data = f0.data; in0_dest = f0.dest;
    in1_valid = v1; in1_data = f1.data; in1_dest = f1.dest;
  endtask

  task automatic check_log(input string name, input int k, input int idx,
                           input logic [DW-1:0] d, input logic s);
    if (idx >= log_d[k].size()) begin
      fail_now(name);
    end else begin
      check({name, "_data"}, int'(log_d[k][idx]), int'(d));
      check({name, "_src"}, int'(log_s[k][idx]), int'(s));
    end
  endtask

  // Holds each input valid until its flit is accepted.
  task automatic send_pair(input flit_t a, input flit_t b);
    bit done0 = 0, done1 = 0, acc0, acc1;
    int guard = 0;
    drive(1'b1, a, 1'b1, b);
    while (!(done0 && done1)) begin
      in0_valid  = !done0;
      in1_valid  = !done1;
      out0_ready = ($urandom_range(3) != 0);
      out1_ready = ($urandom_range(3) != 0);
      acc0 = in0_valid && in0_ready;
      acc1 = in1_valid && in1_ready;
      step();
      done0 |= acc0;
      done1 |= acc1;
      guard++;
      if (guard > 50) begin
        fail_now("send_pair_timeout");
        break;
      end
    end
    in0_valid = 1'b0;
    in1_valid = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every output handshake, checks hold
  // stability under backpressure and the crossbar setting of each grant.
  initial begin : monitor
    logic          pf [2];
    logic          ph [2];
    logic [DW-1:0] pd [2];
    logic          ps [2];
    logic          ov [2], ordy [2], os [2];
    logic [DW-1:0] od [2];
    logic          exp_cross, any_g, cr;
    logic [DW-1:0] e;
    int            idx;
    pf = '{1'b0, 1'b0};
    ph = '{1'b0, 1'b0};
    exp_cross = XBAR_STRAIGHT;
    forever begin
      @(negedge clk);
      if (rst) begin
        pf = '{1'b0, 1'b0};
        ph = '{1'b0, 1'b0};
        exp_cross = XBAR_STRAIGHT;
        continue;
      end
      ov   = '{out0_valid, out1_valid};
      ordy = '{out0_ready, out1_ready};
      os   = '{out0_src, out1_src};
      od   = '{out0_data, out1_data};
      any_g = 1'b0;
      cr    = 1'b0;
      for (int k = 0; k < 2; k++) begin
        if (pf[k] && ov[k]) begin
          any_g = 1'b1;
          if (os[k] != 1'(k)) cr = 1'b1;
        end
        if (ph[k]) begin
          check($sformatf("hold_valid%0d", k), int'(ov[k]), 1);
          check($sformatf("hold_data%0d", k), int'(od[k]), int'(pd[k]));
          check($sformatf("hold_src%0d", k), int'(os[k]), int'(ps[k]));
        end
        if (ov[k] && ordy[k]) begin
          idx = int'({os[k], 1'(k)});
          if (exp_q[idx].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_out%0d: got data %0h src %0d, expected none", k, od[k], os[k]);
          end else begin
            e = exp_q[idx].pop_front();
            check($sformatf("out%0d_data", k), int'(od[k]), int'(e));
          end
          log_d[k].push_back(od[k]);
          log_s[k].push_back(os[k]);
        end
        pf[k] = !ov[k] || ordy[k];
        ph[k] = ov[k] && !ordy[k];
        pd[k] = od[k];
        ps[k] = os[k];
      end
      if (any_g) exp_cross = cr;
      check("xbar_cross", int'(xbar_cross), int'(exp_cross));
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    flit_t a, b;
    int    guard;
    @(posedge clk);
    #1;
    do_reset();

    // Reset state
    check("rst_out0_valid", int'(out0_valid), 0);
    check("rst_out1_valid", int'(out1_valid), 0);
    check("rst_out0_data", int'(out0_data), 0);
    check("rst_out1_src", int'(out1_src), 0);
    check("rst_cross", int'(xbar_cross), 0);
    check("rst_in0_ready", int'(in0_ready), 1);
    check("rst_in1_ready", int'(in1_ready), 1);

    // Single crossed flit: minimum latency of two edges
    a = '{data: 4'h3, dest: DEST_OUT1};
    b = '{data: 4'h0, dest: DEST_OUT0};
    drive(1'b1, a, 1'b0, b);
    step();
    in0_valid = 1'b0;
    check("lat_early_out1_valid", int'(out1_valid), 0);
    step();
    check("lat_out1_valid", int'(out1_valid), 1);
    check("lat_out1_data", int'(out1_data), 3);
    check("lat_out1_src", int'(out1_src), 0);
    check("lat_cross", int'(xbar_cross), 1);
    check("lat_out0_valid", int'(out0_valid), 0);
    idle(2);

    // Two straight flits in the same cycle
    do_reset();
    drive(1'b1, '{data: 4'hA, dest: DEST_OUT0}, 1'b1, '{data: 4'h5, dest: DEST_OUT1});
    step();
    idle(1);
    check("par_out0_valid", int'(out0_valid), 1);
    check("par_out1_valid", int'(out1_valid), 1);
    check("par_out0_data", int'(out0_data), 'hA);
    check("par_out1_data", int'(out1_data), 'h5);
    check("par_cross", int'(xbar_cross), 0);
`ifdef XBAR_CONFLICT_CNT_EN
    check("par_conflict_cnt", int'(conflict_cnt), 0);
`endif
    idle(2);

    // Conflict on out0: round-robin alternation starting with in0
    do_reset();
    drive(1'b1, '{data: 4'h1, dest: DEST_OUT0}, 1'b1, '{data: 4'h2, dest: DEST_OUT0});
    step();
    step();
    idle(6);
    check("rr_count", log_d[0].size(), 4);
    check_log("rr0", 0, 0, 4'h1, 1'b0);
    check_log("rr1", 0, 1, 4'h2, 1'b1);
    check_log("rr2", 0, 2, 4'h1, 1'b0);
    check_log("rr3", 0, 3, 4'h2, 1'b1);
`ifdef XBAR_CONFLICT_CNT_EN
    check("rr_conflict_cnt", int'(conflict_cnt), 3);
`endif

    // Backpressure on out0
    do_reset();
    out0_ready = 1'b0;
    b = '{data: 4'h0, dest: DEST_OUT0};
    drive(1'b1, '{data: 4'h7, dest: DEST_OUT0}, 1'b0, b);
    step();
    drive(1'b1, '{data: 4'h8, dest: DEST_OUT0}, 1'b0, b);
    step();
    drive(1'b1, '{data: 4'h9, dest: DEST_OUT0}, 1'b0, b);
    step();
    check("bp_in0_ready_full", int'(in0_ready), 0);
    check("bp_out0_valid", int'(out0_valid), 1);
    check("bp_out0_data", int'(out0_data), 7);
    drive(1'b1, '{data: 4'hF, dest: DEST_OUT0}, 1'b0, b);
    step();
    idle(3);
    check("bp_out0_held", int'(out0_data), 7);
    check("bp_in0_ready_held", int'(in0_ready), 0);
    out0_ready = 1'b1;
    idle(6);
    check("bp_count", log_d[0].size(), 3);
    check_log("bp0", 0, 0, 4'h7, 1'b0);
    check_log("bp1", 0, 1, 4'h8, 1'b0);
    check_log("bp2", 0, 2, 4'h9, 1'b0);

    // Reset in the middle of a blocked stream; prio was moved to in1 first
    do_reset();
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, '{data: 4'(i + 1), dest: DEST_OUT0}, 1'b1, '{data: 4'(i + 8), dest: DEST_OUT0});
      step();
    end
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    check("mid_in0_full", int'(in0_ready), 0);
    check("mid_in1_full", int'(in1_ready), 0);
    check("mid_out0_valid", int'(out0_valid), 1);
    do_reset();
    check("mid_rst_out0_valid", int'(out0_valid), 0);
    check("mid_rst_out1_valid", int'(out1_valid), 0);
    check("mid_rst_in0_ready", int'(in0_ready), 1);
    check("mid_rst_in1_ready", int'(in1_ready), 1);
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    drive(1'b1, '{data: 4'h4, dest: DEST_OUT0}, 1'b1, '{data: 4'h5, dest: DEST_OUT0});
    step();
    idle(5);
    check("mid_count", log_d[0].size(), 2);
    check_log("mid_win", 0, 0, 4'h4, 1'b0);
    check_log("mid_lose", 0, 1, 4'h5, 1'b1);

    // Exhaustive data pairs and destination combinations
    do_reset();
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        for (int dc = 0; dc < 4; dc++) begin
          a = '{data: 4'(i), dest: 1'(dc)};
          b = '{data: 4'(j), dest: 1'(dc >> 1)};
          send_pair(a, b);
        end
      end
    end

    // Free-running random traffic and backpressure
    for (int n = 0; n < 3000; n++) begin
      in0_valid  = 1'($urandom_range(1));
      in0_data   = 4'($urandom_range(15));
      in0_dest   = 1'($urandom_range(1));
      in1_valid  = 1'($urandom_range(1));
      in1_data   = 4'($urandom_range(15));
      in1_dest   = 1'($urandom_range(1));
      out0_ready = ($urandom_range(3) != 0);
      out1_ready = ($urandom_range(3) != 0);
      step();
    end

    // Drain and confirm nothing was lost
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    guard = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0 &&
           guard < 100) begin
      idle(1);
      guard++;
    end
    idle(2);
    for (int i = 0; i < 4; i++) check($sformatf("drain_q%0d", i), exp_q[i].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/crossbar_2x2_sched.md
Name: crossbar_2x2_sched

Overview:
- Sequential front end for the 2x2 4-bit crossbar datapath: it sits on the request side and generates the crossbar setting that the crossbar itself only consumes.
- Each input port carries a small FIFO of flits. Each flit is DATA_W data bits plus a 1-bit destination.
- Each cycle the block resolves head-of-line requests, with round-robin on output conflict, and drives two registered output ports using valid/ready handshakes.

Parameters:
- DATA_W, 4, flit payload width.
- FIFO_DEPTH, 2, entries per input FIFO; power of two, at least 2.
- CNT_W, 8, width of the conflict counter (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in0_valid  in  1  input 0 flit valid.
- in0_ready  out  1  input 0 can accept a flit (FIFO not full).
- in0_data  in  DATA_W  input 0 payload.
- in0_dest  in  1  input 0 destination: 0 = out0, 1 = out1.
- in1_valid, in1_ready, in1_data, in1_dest: same as input 0, for input 1.
- out0_valid  out  1  output 0 holds a flit.
- out0_ready  in  1  downstream consumes the flit on out0.
- out0_data  out  DATA_W  output 0 payload.
- out0_src  out  1  source input of the flit on out0.
- out1_valid, out1_ready, out1_data, out1_src: same as output 0, for output 1.
- xbar_cross  out  1  registered crossbar setting of the last transfer: 1 = crossed, 0 = straight.

Behaviour:
- Reset (clk edge with rst=1):
  - both FIFOs empty, so in*_ready=1;
  - out*_valid=0, out*_data=0, out*_src=0;
  - xbar_cross=0, priority pointer prio=0 (input 0 favoured).
- Reset mid-operation discards all buffered and output flits with no drain.
- Input handshake:
  - a flit is pushed when in*_valid && in*_ready;
  - in*_ready = !full, with no same-cycle bypass when full (in_ready stays 0 even if a pop occurs that cycle);
  - data and dest are stored together.
- Output slot k is free when !outk_valid || outk_ready.
- Grant logic, combinational on the FIFO heads:
  - Head i requests output dest_i when its FIFO is non-empty.
  - Distinct destinations: each head is granted if its target slot is free.
  - Same destination: only the input equal to prio is eligible. It is granted if the slot is free, and the loser waits.
  - Conflict pointer update: after any granted conflict, prio <= loser. prio is unchanged when there is no conflict or when the slot is blocked.
- Granted flit:
  - popped from its FIFO;
  - loaded into outk_data/outk_src with outk_valid=1 on the same edge.
- A free, ungranted slot clears outk_valid.
- xbar_cross updates only on cycles with at least one grant:
  - cross = 1 if any granted flit had src != dest;
  - when two flits are granted, both agree by construction.
- Latency: a flit pushed at edge N is visible on out* after edge N+1, i.e. 2 cycles minimum under no contention and no backpressure.
- Ordering: flits from the same input to the same output stay in order. HOL blocking is intentional.
- FIFO pointers use log2(FIFO_DEPTH)+1 bits. Full and empty come from MSB and index comparison. Wrap-around is natural modulo.
- Output data stays stable while outk_valid && !outk_ready.

Optional Feature:
- Macro: XBAR_CONFLICT_CNT_EN.
- Defined:
  - adds output port conflict_cnt (out, CNT_W), reset to 0;
  - increments on every cycle in which both heads are valid with the same destination, whether or not a grant occurs;
  - saturates at all-ones.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package xbar_pkg: DATA_W default, flit struct {data, dest}, constants DEST_OUT0=0 / DEST_OUT1=1, XBAR_STRAIGHT=0 / XBAR_CROSS=1.
- One sub-module is natural: xbar_flit_fifo (synchronous FIFO with push/pop/full/empty, parameterised depth and width), instantiated twice.
- The arbiter and output registers stay in the top module.

Test Plan:
- Reset, then in0 sends data=4'h3 dest=1 with outputs ready -> after 2 cycles out1_valid=1, out1_data=3, out1_src=0, xbar_cross=1; out0_valid=0.
- Same cycle: in0 sends 4'hA dest=0 and in1 sends 4'h5 dest=1 -> both outputs valid together, out0_data=A, out1_data=5, xbar_cross=0, no conflict count.
- Conflict: both inputs send dest=0 (in0 4'h1, in1 4'h2) for 2 cycles each -> out0 sequence 1,2,1,2 (alternating, starting with in0); conflict_cnt counts each cycle both heads collide, when the macro is defined.
- Backpressure: hold out0_ready=0 while in0 streams 4'h7,4'h8,4'h9 to dest 0 -> out0_data held at 7; in0_ready=0 once the FIFO holds 2; release gives 7,8,9 in order with no loss.
- Reset mid-stream: full FIFOs and valid outputs, assert rst for 1 cycle -> all out*_valid=0, in*_ready=1, prio=0; the next conflict is won by in0.
- Exhaustive sweep: all 16x16 data pairs × 4 dest combos through the self-checking scoreboard -> every flit arrives exactly once at out[dest] with the correct src.
